button_ctrl: RTL and testbench

Parametrised, memory-mapped push-button input controller for the GPIO address region. It synchronises and debounces N_BTN raw button inputs and exposes debounced levels through a registered 32-bit read port. Sticky press/release event flags are cleared by write-1-to-clear, and a maskable level interrupt is driven from them. It replaces the single-bit, undebounced button read path.

---
 rtl/gpio_pkg.sv | 19 +
 rtl/button_ctrl_if.sv | 23 ++
 rtl/button_debounce.sv | 67 ++++++
 rtl/button_ctrl.sv | 129 ++++++++++++
 tb/tb_button_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO address region: register word offsets and
// field positions used by the button controller and its bus interface.
package gpio_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] REG_STATE   = 2'd0;
    localparam logic [1:0] REG_PRESS   = 2'd1;
    localparam logic [1:0] REG_RELEASE = 2'd2;
    localparam logic [1:0] REG_IRQ_EN  = 2'd3;

    // Bit position of RELEASE[0]'s enable inside the IRQ_EN word.
    localparam int IRQ_REL_BASE = 16;

    function automatic logic [1:0] reg_index(input logic [DATA_W-1:0] address);
        return address[3:2];
    endfunction

endpackage

// File: rtl/button_ctrl_if.sv
// Memory-mapped register bus of the button controller: read/write strobes,
// byte address, write data, registered read data and the level interrupt.
interface button_ctrl_if;
    import gpio_pkg::*;

    logic              ren;
    logic              wen;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              irq;

    modport master (
        output ren, wen, address, data_in,
        input  data_out, irq
    );

    modport slave (
        input  ren, wen, address, data_in,
        output data_out, irq
    );

endinterface

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, stability counter and the accepted
// level, with single-cycle rise/fall strobes aligned to the level change.
module button_debounce
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic lvl,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic IDLE_PIN = ACTIVE_LOW;

    logic             sync1_reg;
    logic             sync2_reg;
    logic             lvl_reg;
    logic             lvl_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             sample;
    logic             differ;
    logic             at_tc;

    // Synchronisers reset to the idle pin level so no edge is seen after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= IDLE_PIN;
            sync2_reg <= IDLE_PIN;
            cnt_reg   <= '0;
            lvl_reg   <= 1'b0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            cnt_reg   <= cnt_next;
            lvl_reg   <= lvl_next;
        end
    end

    assign sample = ACTIVE_LOW ? ~sync2_reg : sync2_reg;
    assign differ = (sample != lvl_reg);
    assign at_tc  = (cnt_reg == CNT_TC);

    always_comb begin
        cnt_next = '0;
        lvl_next = lvl_reg;
        if (differ) begin
            if (at_tc) begin
                lvl_next = ~lvl_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // Strobes are combinational so the event flags load on the same edge as lvl.
    assign rise = differ && at_tc && !lvl_reg;
    assign fall = differ && at_tc &&  lvl_reg;
    assign lvl  = lvl_reg;

endmodule

// File: rtl/button_ctrl.sv
// Debounced push-button controller: per-channel debouncers, sticky W1C
// press/release flags, interrupt enables, registered read port and irq.
module button_ctrl
    import gpio_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    button_ctrl_if.slave     bus
);

    logic [N_BTN-1:0]  lvl;
    logic [N_BTN-1:0]  rise;
    logic [N_BTN-1:0]  fall;

    logic [N_BTN-1:0]  press_reg;
    logic [N_BTN-1:0]  press_next;
    logic [N_BTN-1:0]  release_reg;
    logic [N_BTN-1:0]  release_next;
    logic [N_BTN-1:0]  press_en_reg;
    logic [N_BTN-1:0]  press_en_next;
    logic [N_BTN-1:0]  rel_en;
    logic [DATA_W-1:0] irq_en_rd;

    logic [DATA_W-1:0] data_out_reg;
    logic [DATA_W-1:0] rd_data;
    logic              irq_reg;
    logic              irq_next;

    logic [1:0]        reg_sel;
    logic              wr_press;
    logic              wr_release;
    logic              wr_irq_en;
    logic [N_BTN-1:0]  wr_bits;
    logic              unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_chan
            button_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_debounce (
                .clk     (clk),
                .reset   (reset),
                .btn_raw (btn_raw[gi]),
                .lvl     (lvl[gi]),
                .rise    (rise[gi]),
                .fall    (fall[gi])
            );
        end
    endgenerate

    assign reg_sel    = reg_index(bus.address);
    assign wr_press   = bus.wen && (reg_sel == REG_PRESS);
    assign wr_release = bus.wen && (reg_sel == REG_RELEASE);
    assign wr_irq_en  = bus.wen && (reg_sel == REG_IRQ_EN);
    assign wr_bits    = bus.data_in[N_BTN-1:0];

    // Clear first, then OR in new events: a coincident set beats the W1C.
    always_comb begin
        press_next    = (press_reg   & ~(wr_press   ? wr_bits : '0)) | rise;
        release_next  = (release_reg & ~(wr_release ? wr_bits : '0)) | fall;
        press_en_next = wr_irq_en ? wr_bits : press_en_reg;
    end

    // Release enables only have a home in IRQ_EN when they fit above bit 16.
    generate
        if (N_BTN <= IRQ_REL_BASE) begin : g_rel_en
            logic [N_BTN-1:0] rel_en_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rel_en_reg <= '0;
                end else if (wr_irq_en) begin
                    rel_en_reg <= bus.data_in[IRQ_REL_BASE +: N_BTN];
                end
            end

            assign rel_en    = rel_en_reg;
            assign irq_en_rd = DATA_W'(press_en_reg) | (DATA_W'(rel_en_reg) << IRQ_REL_BASE);
        end else begin : g_no_rel_en
            assign rel_en    = '0;
            assign irq_en_rd = DATA_W'(press_en_reg);
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATE:   rd_data = DATA_W'(lvl);
            REG_PRESS:   rd_data = DATA_W'(press_reg);
            REG_RELEASE: rd_data = DATA_W'(release_reg);
            REG_IRQ_EN:  rd_data = irq_en_rd;
            default:     rd_data = '0;
        endcase
    end

    assign irq_next = (|(press_reg & press_en_reg)) | (|(release_reg & rel_en));

    // Read data is taken from pre-write contents since rd_data uses the _reg values.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_reg    <= '0;
            release_reg  <= '0;
            press_en_reg <= '0;
            data_out_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            press_reg    <= press_next;
            release_reg  <= release_next;
            press_en_reg <= press_en_next;
            irq_reg      <= irq_next;
            if (bus.ren) begin
                data_out_reg <= rd_data;
            end
        end
    end

    assign bus.data_out = data_out_reg;
    assign bus.irq      = irq_reg;

    assign unused_bits = ^{bus.address[31:4], bus.address[1:0], bus.data_in};

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl with a short debounce window; read
// results are pushed to a scoreboard queue at issue and popped on data_out.
module tb_button_ctrl;
    import gpio_pkg::*;

    localparam int N_BTN = 4;
    localparam int DEB   = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_BTN-1:0] btn_raw;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    button_ctrl_if bus_if();

    button_ctrl #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] addr_of(input logic [1:0] sel);
        return {28'h0, sel, 2'b00};
    endfunction

    task automatic bus_write(input logic [1:0] sel, input logic [31:0] data);
        bus_if.wen     = 1'b1;
        bus_if.address = addr_of(sel);
        bus_if.data_in = data;
        tick();
        bus_if.wen     = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        bus_if.ren     = 1'b1;
        bus_if.address = addr_of(sel);
        exp_q.push_back(exp);
        tick();
        bus_if.ren     = 1'b0;
        check_eq(tag, bus_if.data_out, exp_q.pop_front());
    endtask

    // With ren held, push the value expected after n more edges and compare it.
    task automatic stream_expect(input string tag, input int n, input logic [31:0] exp);
        exp_q.push_back(exp);
        tick(n);
        check_eq(tag, bus_if.data_out, exp_q.pop_front());
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check_eq(tag, {31'b0, bus_if.irq}, {31'b0, exp});
    endtask

    initial begin
        reset          = 1'b1;
        btn_raw        = 4'hF;
        bus_if.ren     = 1'b0;
        bus_if.wen     = 1'b0;
        bus_if.address = '0;
        bus_if.data_in = '0;
        tick(3);
        check_eq("reset_data_out", bus_if.data_out, 32'h0);
        check_irq("reset_irq", 1'b0);
        reset = 1'b0;
        tick(40);
        bus_read("idle_state", REG_STATE, 32'h0);
        bus_read("idle_press", REG_PRESS, 32'h0);
        check_irq("idle_irq", 1'b0);

        // Button 2 press: lvl changes on edge 18, visible in STATE one edge later.
        btn_raw[2]     = 1'b0;
        bus_if.ren     = 1'b1;
        bus_if.address = addr_of(REG_STATE);
        stream_expect("lvl2_before_18", 18, 32'h0);
        stream_expect("lvl2_at_18", 1, 32'h4);
        bus_if.ren = 1'b0;
        tick(11);
        bus_read("held_state", REG_STATE, 32'h4);
        bus_read("held_press", REG_PRESS, 32'h4);
        bus_read("held_release", REG_RELEASE, 32'h0);
        btn_raw[2] = 1'b1;
        tick(20);
        bus_read("rel2_release", REG_RELEASE, 32'h4);
        bus_read("rel2_state", REG_STATE, 32'h0);
        bus_write(REG_PRESS, 32'hF);
        bus_write(REG_RELEASE, 32'hF);
        bus_read("w1c_press", REG_PRESS, 32'h0);
        bus_read("w1c_release", REG_RELEASE, 32'h0);

        // Bouncing input never stays stable long enough to be accepted.
        for (int i = 0; i < 20; i++) begin
            btn_raw[0] = ~btn_raw[0];
            tick(5);
        end
        btn_raw[0] = 1'b1;
        tick(20);
        bus_read("bounce_state", REG_STATE, 32'h0);
        bus_read("bounce_press", REG_PRESS, 32'h0);
        bus_read("bounce_release", REG_RELEASE, 32'h0);

        // Press interrupt on button 0.
        bus_write(REG_IRQ_EN, 32'h1);
        bus_read("irq_en_rd", REG_IRQ_EN, 32'h1);
        btn_raw[0] = 1'b0;
        tick(18);
        check_irq("irq_before", 1'b0);
        tick(1);
        check_irq("irq_set", 1'b1);
        bus_write(REG_PRESS, 32'h1);
        check_irq("irq_at_w1c", 1'b1);
        tick(1);
        check_irq("irq_cleared", 1'b0);
        bus_read("press0_cleared", REG_PRESS, 32'h0);

        // W1C of PRESS[1] on the very edge lvl[1] rises: the set wins.
        btn_raw[1] = 1'b0;
        tick(17);
        bus_if.wen     = 1'b1;
        bus_if.address = addr_of(REG_PRESS);
        bus_if.data_in = 32'h2;
        tick(1);
        bus_if.wen = 1'b0;
        bus_read("collide_press", REG_PRESS, 32'h2);
        check_irq("collide_irq_masked", 1'b0);
        bus_write(REG_PRESS, 32'h2);
        bus_read("collide_cleared", REG_PRESS, 32'h0);

        // Enable masking, ignored STATE write, release interrupt.
        bus_write(REG_IRQ_EN, 32'hFFFF_FFFF);
        bus_read("irq_en_all", REG_IRQ_EN, 32'h000F_000F);
        bus_write(REG_STATE, 32'hF);
        bus_read("state_ro", REG_STATE, 32'h3);
        btn_raw[1] = 1'b1;
        tick(18);
        check_irq("rel_irq_before", 1'b0);
        tick(1);
        check_irq("rel_irq_set", 1'b1);
        bus_write(REG_IRQ_EN, 32'h0);
        tick(1);
        check_irq("rel_irq_masked", 1'b0);
        bus_read("rel1_flag", REG_RELEASE, 32'h2);
        btn_raw = 4'hF;
        tick(25);
        bus_write(REG_PRESS, 32'hF);
        bus_write(REG_RELEASE, 32'hF);

        // Reset at count 10 of a button 3 press discards the count.
        btn_raw[3] = 1'b0;
        tick(12);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("rst2_data_out", bus_if.data_out, 32'h0);
        check_irq("rst2_irq", 1'b0);
        bus_if.ren     = 1'b1;
        bus_if.address = addr_of(REG_PRESS);
        stream_expect("rst_no_early_event", 18, 32'h0);
        stream_expect("rst_press3", 1, 32'h8);
        bus_if.ren = 1'b0;
        bus_read("rst_state3", REG_STATE, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
